// File: rtl/psum_deskew_collector.sv
// Re-aligns the column-skewed partial sums leaving the systolic array into one
// vector per cycle and buffers them in a first-word-fall-through FIFO.
module psum_deskew_collector #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       psum_valid_in,
  input  logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] psum_in_flat,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [SYSTOLIC_SIZE*PARTIAL_SUM_WIDTH-1:0] out_psum_flat,
  output logic [$clog2(FIFO_DEPTH):0]                fifo_level,
  output logic                                       overflow,
  input  logic                                       clear_err,
  output logic [15:0]                                vec_count
);

  localparam int PSW   = PARTIAL_SUM_WIDTH;
  localparam int VW    = SYSTOLIC_SIZE * PSW;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PSW-1:0]           aligned_col [SYSTOLIC_SIZE];
  logic [VW-1:0]            aligned_vec;
  logic [SYSTOLIC_SIZE-2:0] valid_pipe_q;
  logic                     aligned_valid;

  logic [VW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      vec_count_q, vec_count_d;
  logic             full, pop, push_ok, drop;

  // Column j waits SYSTOLIC_SIZE-1-j cycles so every column lands on the same beat.
  for (genvar j = 0; j < SYSTOLIC_SIZE; j++) begin : g_col
    localparam int DEPTH = SYSTOLIC_SIZE - 1 - j;
    if (DEPTH == 0) begin : g_pass
      assign aligned_col[j] = psum_in_flat[j*PSW +: PSW];
    end else begin : g_dly
      logic [PSW-1:0] sr_q [DEPTH];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
        end else begin
          // NOTE: non-blocking assignments let every stage read the pre-edge value of its neighbour.
          sr_q[0] <= psum_in_flat[j*PSW +: PSW];
          for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
        end
      end
      assign aligned_col[j] = sr_q[DEPTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_pipe_q <= '0;
    end else begin
      valid_pipe_q[0] <= psum_valid_in;
      for (int k = 1; k < SYSTOLIC_SIZE - 1; k++) valid_pipe_q[k] <= valid_pipe_q[k-1];
    end
  end

  assign aligned_valid = valid_pipe_q[SYSTOLIC_SIZE-2];

  always_comb begin
    // NOTE: a default assignment first keeps this block free of inferred latches.
    aligned_vec = '0;
    for (int j = 0; j < SYSTOLIC_SIZE; j++) aligned_vec[j*PSW +: PSW] = aligned_col[j];
  end

  assign out_valid     = (level_q != '0);
  assign out_psum_flat = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;
  assign vec_count     = vec_count_q;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    full        = (level_q == LVL_W'(FIFO_DEPTH));
    pop         = out_valid && out_ready;
    push_ok     = aligned_valid && (!full || pop);
    drop        = aligned_valid && full && !pop;
    level_d     = level_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    vec_count_d = vec_count_q;
    overflow_d  = overflow_q;
    if (push_ok && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - LVL_W'(1);
    end
    if (push_ok) begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(1);
      vec_count_d = vec_count_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    // A fresh drop outranks a simultaneous clear so no error is lost.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_err) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      vec_count_q <= '0;
    end else begin
      level_q     <= level_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      vec_count_q <= vec_count_d;
    end
  end

  // NOTE: storage is not reset; an empty level masks stale entries and the output is gated to zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= aligned_vec;
  end

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Directed bench for psum_deskew_collector: latency, streaming, overflow,
// simultaneous push/pop, error clearing and mid-flight reset.
module tb_psum_deskew_collector;

  localparam int SZ  = 8;
  localparam int PSW = 19;
  localparam int VW  = SZ * PSW;

  logic          clk = 1'b0;
  logic          rst;
  logic          psum_valid_in;
  logic [VW-1:0] psum_in_flat;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_psum_flat;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          clear_err;
  logic [15:0]   vec_count;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int sched_start = 0;
  int sched_n = 0;
  int sched_mode = 0;

  always #5 clk = ~clk;

  psum_deskew_collector dut (
    .clk          (clk),
    .rst          (rst),
    .psum_valid_in(psum_valid_in),
    .psum_in_flat (psum_in_flat),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_psum_flat(out_psum_flat),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clear_err    (clear_err),
    .vec_count    (vec_count)
  );

  function automatic logic [PSW-1:0] col_val(input int mode, input int k, input int j);
    case (mode)
      0:       return PSW'(100 + j);
      1:       return PSW'(16 * k + j);
      2:       return PSW'('h40000 + 256 * k + j);
      3:       return PSW'(1000 * (k + 1) + j);
      4:       return PSW'('h2AAAA + 64 * k + j);
      default: return PSW'(500 + 10 * k + j);
    endcase
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int mode, input int k);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < SZ; j++) v[j*PSW +: PSW] = col_val(mode, k, j);
    return v;
  endfunction

  // Column j of vector k is presented at sched_start+k+j; idle columns carry junk.
  task automatic drive();
    logic [VW-1:0] bus;
    int k;
    bus = '0;
    for (int j = 0; j < SZ; j++) begin
      k = t - j - sched_start;
      if (k >= 0 && k < sched_n) bus[j*PSW +: PSW] = col_val(sched_mode, k, j);
      else                       bus[j*PSW +: PSW] = PSW'('h71234 ^ j);
    end
    psum_in_flat  = bus;
    psum_valid_in = (t >= sched_start) && (t < sched_start + sched_n);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    t++;
    drive();
  endtask

  task automatic sched(input int start, input int n, input int mode);
    sched_start = start;
    sched_n     = n;
    sched_mode  = mode;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; clear_err = 1'b0;
    sched(0, 0, 0);
    drive();
    cycle();
    cycle();
    check("rst_valid", out_valid, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_psum", out_psum_flat, '0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_cnt", vec_count, 16'd0);

    // Single vector: valid at cycle 10, output only at cycle 18.
    rst = 1'b0; t = 0; out_ready = 1'b1;
    sched(10, 1, 0);
    drive();
    repeat (30) begin
      cycle();
      check("t1_valid", out_valid, (t == 18));
      if (t == 18) begin
        check("t1_psum", out_psum_flat, exp_vec(0, 0));
        check("t1_cnt", vec_count, 16'd1);
      end
      if (t == 19) check("t1_psum_idle", out_psum_flat, '0);
    end

    // Eight back-to-back vectors stream through without gaps.
    t = 0;
    sched(10, 8, 1);
    drive();
    repeat (30) begin
      cycle();
      check("t2_valid", out_valid, (t >= 18 && t <= 25));
      if (t >= 18 && t <= 25) check("t2_psum", out_psum_flat, exp_vec(1, t - 18));
      check("t2_level_le1", (fifo_level <= 3'd1), 1'b1);
    end
    check("t2_cnt", vec_count, 16'd9);

    // Stalled consumer: four accepted, the fifth and sixth dropped.
    t = 0; out_ready = 1'b0;
    sched(5, 6, 2);
    drive();
    repeat (25) begin
      cycle();
      if (t == 16) begin
        check("t3_level_full", fifo_level, 3'd4);
        check("t3_ovf_before", overflow, 1'b0);
      end
      if (t == 17) check("t3_ovf_set", overflow, 1'b1);
      if (t == 18) begin
        check("t3_cnt", vec_count, 16'd13);
        check("t3_level_hold", fifo_level, 3'd4);
      end
      if (t == 19) out_ready = 1'b1;
      if (t >= 19 && t <= 22) check("t3_drain", out_psum_flat, exp_vec(2, t - 19));
      if (t == 23) begin
        check("t3_empty", out_valid, 1'b0);
        check("t3_ovf_sticky", overflow, 1'b1);
        clear_err = 1'b1;
      end
      if (t == 24) begin
        check("t3_ovf_clear", overflow, 1'b0);
        clear_err = 1'b0;
      end
    end

    // Full FIFO with push and pop together, then clear coincident with a drop.
    t = 0; out_ready = 1'b0;
    sched(0, 5, 3);
    drive();
    repeat (28) begin
      cycle();
      if (t == 11) begin
        check("t4_level_full", fifo_level, 3'd4);
        check("t4_head_oldest", out_psum_flat, exp_vec(3, 0));
        out_ready = 1'b1;
      end
      if (t == 12) begin
        out_ready = 1'b0;
        check("t4_level_same", fifo_level, 3'd4);
        check("t4_head_next", out_psum_flat, exp_vec(3, 1));
        check("t4_ovf_clean", overflow, 1'b0);
        check("t4_cnt", vec_count, 16'd18);
        sched(14, 1, 4);
      end
      if (t == 21) clear_err = 1'b1;
      if (t == 22) begin
        check("t4_set_wins", overflow, 1'b1);
      end
      if (t == 23) begin
        clear_err = 1'b0;
        out_ready = 1'b1;
        check("t4_ovf_clear", overflow, 1'b0);
      end
      if (t >= 23 && t <= 26) check("t4_drain", out_psum_flat, exp_vec(3, t - 22));
      if (t == 27) begin
        check("t4_empty_valid", out_valid, 1'b0);
        check("t4_empty_psum", out_psum_flat, '0);
        check("t4_cnt_after", vec_count, 16'd18);
      end
    end

    // Reset with three buffered and two in the deskew pipe discards everything.
    t = 0; out_ready = 1'b0;
    sched(0, 5, 5);
    drive();
    repeat (32) begin
      cycle();
      if (t == 10) begin
        check("t5_level_pre", fifo_level, 3'd3);
        rst = 1'b1;
      end
      if (t == 11) begin
        rst = 1'b0;
        out_ready = 1'b1;
        check("t5_level", fifo_level, 3'd0);
        check("t5_cnt", vec_count, 16'd0);
        check("t5_psum", out_psum_flat, '0);
      end
      if (t >= 11) check("t5_quiet", out_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
